// File: rtl/keypad_scanner.sv
// 3x3 active-low matrix scanner with scan-level debounce and single-key press events.
// Optional WAM_HIT_CHECK_EN adds hit/miss strobes judged against the lit-mole mask.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] key_matrix_row,
  output logic [2:0] key_matrix_col,
  input  logic [8:0] lights,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
`ifdef WAM_HIT_CHECK_EN
  ,
  output logic       hit,
  output logic       miss
`endif
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {DRIVE0, DRIVE1, DRIVE2} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       row_s1_q, row_s2_q;
  logic [8:0]       snap_q, snap_d;
  logic [8:0]       prev_q, prev_d;
  logic [3:0]       match_q, match_d;
  logic [8:0]       stable_q, stable_d;
  logic             lockout_q, lockout_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;

  logic             tc;
  logic [2:0]       samp;
  logic [8:0]       full_snap;
  logic [3:0]       ones;

  always_comb begin
    state_d        = state_q;
    div_d          = div_q + 1'b1;
    snap_d         = snap_q;
    prev_d         = prev_q;
    match_d        = match_q;
    stable_d       = stable_q;
    lockout_d      = lockout_q;
    valid_d        = 1'b0;
    code_d         = code_q;
    key_matrix_col = 3'b110;
    full_snap      = snap_q;
    ones           = 4'd0;
    samp           = ~row_s2_q;
    tc             = (div_q == DIV_W'(SCAN_DIV - 1));

    case (state_q)
      DRIVE0:  key_matrix_col = 3'b110;
      DRIVE1:  key_matrix_col = 3'b101;
      DRIVE2:  key_matrix_col = 3'b011;
      default: key_matrix_col = 3'b110;
    endcase

    if (tc) begin
      div_d = '0;
      // Each column contributes one bit per row: index row*3+col.
      case (state_q)
        DRIVE0: begin
          full_snap[0] = samp[0];
          full_snap[3] = samp[1];
          full_snap[6] = samp[2];
          state_d      = DRIVE1;
        end
        DRIVE1: begin
          full_snap[1] = samp[0];
          full_snap[4] = samp[1];
          full_snap[7] = samp[2];
          state_d      = DRIVE2;
        end
        default: begin
          full_snap[2] = samp[0];
          full_snap[5] = samp[1];
          full_snap[8] = samp[2];
          state_d      = DRIVE0;
        end
      endcase
      snap_d = full_snap;

      if (state_q == DRIVE2) begin
        if (full_snap == prev_q) begin
          if (match_q != 4'(DEBOUNCE_SCANS)) match_d = match_q + 4'd1;
        end else begin
          match_d = 4'd1;
        end
        prev_d = full_snap;
        if (match_d == 4'(DEBOUNCE_SCANS)) stable_d = full_snap;
      end
    end

    for (int i = 0; i < 9; i++) ones = ones + 4'(stable_d[i]);

    // Multi-key chords lock out events until the matrix is fully released.
    if (stable_d == 9'd0) lockout_d = 1'b0;
    else if (ones > 4'd1) lockout_d = 1'b1;

    if ((stable_q == 9'd0) && (ones == 4'd1) && !lockout_q) begin
      valid_d = 1'b1;
      for (int i = 0; i < 9; i++) begin
        if (stable_d[i]) code_d = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DRIVE0;
      div_q     <= '0;
      row_s1_q  <= 3'b111;
      row_s2_q  <= 3'b111;
      snap_q    <= '0;
      prev_q    <= '0;
      match_q   <= '0;
      stable_q  <= '0;
      lockout_q <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      row_s1_q  <= key_matrix_row;
      row_s2_q  <= row_s1_q;
      snap_q    <= snap_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      stable_q  <= stable_d;
      lockout_q <= lockout_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = |stable_q;

`ifdef WAM_HIT_CHECK_EN
  // lights is looked at live, in the same cycle key_valid is high.
  assign hit  = valid_q & lights[code_q];
  assign miss = valid_q & ~lights[code_q];
`else
  logic unused_lights;
  assign unused_lights = ^lights;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner against a scan-level debounce/event model.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 3 * SD;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] row;
  logic [2:0] col;
  logic [8:0] lights;
  logic [8:0] pressed;
  logic       key_valid;
  logic       key_held;
  logic [3:0] key_code;
`ifdef WAM_HIT_CHECK_EN
  logic       hit;
  logic       miss;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;
  int exp_strobes = 0;

  logic [8:0] hist[$];
  logic [8:0] m_stable;
  logic [3:0] m_code;

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its column drive onto its row.
  always_comb begin
    row = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (!col[c] && pressed[r*3+c]) row[r] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .key_matrix_row (row),
    .key_matrix_col (col),
    .lights         (lights),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_held       (key_held)
`ifdef WAM_HIT_CHECK_EN
    ,
    .hit            (hit),
    .miss           (miss)
`endif
  );

  always @(negedge clk) if (key_valid === 1'b1) strobes++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_stable = 9'd0;
    m_code   = 4'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"}, 32'(col), 32'(3'b110));
    chk({tag, "_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_held"}, 32'(key_held), 32'd0);
    chk({tag, "_code"}, 32'(key_code), 32'd0);
`ifdef WAM_HIT_CHECK_EN
    chk({tag, "_hit"}, 32'(hit), 32'd0);
    chk({tag, "_miss"}, 32'(miss), 32'd0);
`endif
  endtask

  // One full scan with a fixed key pattern, then judge the scan-end outputs.
  task automatic run_scan(input logic [8:0] pat, input logic [8:0] lit);
    logic [8:0] ns;
    logic [2:0] ec;
    logic       exp_ev;
    bit         same;
    pressed = pat;
    lights  = lit;
    for (int i = 1; i <= SCAN; i++) begin
      @(posedge clk);
      if (i % SD == 2) begin
        @(negedge clk);
        ec = ~(3'b001 << (i / SD));
        chk("col_seq", 32'(col), 32'(ec));
      end
    end
    @(negedge clk);
    hist.push_back(pat);
    if (hist.size() > DB) void'(hist.pop_front());
    ns = m_stable;
    if (hist.size() == DB) begin
      same = 1'b1;
      foreach (hist[k]) if (hist[k] != pat) same = 1'b0;
      if (same) ns = pat;
    end
    exp_ev = (m_stable == 9'd0) && ($countones(ns) == 1);
    if (exp_ev) begin
      for (int k = 0; k < 9; k++) if (ns[k]) m_code = 4'(k);
      exp_strobes++;
    end
    m_stable = ns;
    chk("key_valid", 32'(key_valid), 32'(exp_ev));
    chk("key_code", 32'(key_code), 32'(m_code));
    chk("key_held", 32'(key_held), 32'(m_stable != 9'd0));
`ifdef WAM_HIT_CHECK_EN
    chk("hit", 32'(hit), 32'(exp_ev && lit[m_code]));
    chk("miss", 32'(miss), 32'(exp_ev && !lit[m_code]));
`endif
  endtask

  initial begin
    logic [8:0] pat;
    logic [8:0] lit;
    int kind;
    int nrep;

    resetn  = 1'b0;
    pressed = 9'd0;
    lights  = 9'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    resetn = 1'b1;

    // Idle after reset: column walk only, no events.
    repeat (3) run_scan(9'd0, 9'd0);

    // Clean press and release of key 5.
    repeat (4) run_scan(9'(1 << 5), 9'd0);
    repeat (3) run_scan(9'd0, 9'd0);

    // Bouncing key 5 on alternate scans, then held.
    for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? 9'(1 << 5) : 9'd0, 9'd0);
    repeat (4) run_scan(9'(1 << 5), 9'd0);
    repeat (3) run_scan(9'd0, 9'd0);

    // Chord 0+8, roll to 0 alone, release, then key 3.
    repeat (3) run_scan(9'h101, 9'd0);
    repeat (3) run_scan(9'h001, 9'd0);
    repeat (3) run_scan(9'd0, 9'd0);
    repeat (3) run_scan(9'(1 << 3), 9'd0);
    repeat (3) run_scan(9'd0, 9'd0);

    // Key 4 against a lit and an unlit mole.
    repeat (3) run_scan(9'(1 << 4), 9'h010);
    repeat (3) run_scan(9'd0, 9'h010);
    repeat (3) run_scan(9'(1 << 4), 9'h001);
    repeat (3) run_scan(9'd0, 9'h001);

    // Random patterns held for random numbers of scans.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       pat = 9'd0;
        1, 2:    pat = 9'(1 << $urandom_range(0, 8));
        default: pat = 9'($urandom_range(1, 511));
      endcase
      nrep = $urandom_range(1, 3);
      lit  = 9'($urandom_range(0, 511));
      repeat (nrep) run_scan(pat, lit);
    end
    repeat (2) run_scan(9'd0, 9'd0);

    // Reset during DRIVE1 with key 7 held, then it must re-debounce and fire.
    repeat (3) run_scan(9'(1 << 7), 9'h080);
    repeat (6) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();
    repeat (3) run_scan(9'(1 << 7), 9'h080);
    repeat (2) run_scan(9'd0, 9'd0);

    chk("strobe_count", 32'(strobes), 32'(exp_strobes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
